// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the request/acknowledge signals of the two requesters, the RAM
//   port and the stall request into one interface.
//   Signal names keep the arbiter-relative _i/_o suffixes.
//   Modports:
//     slave  - the arbiter: sees requests and RAM read data, drives acks,
//              read data, the RAM command and stall.
//     master - the environment: pipeline requesters plus the RAM instance.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction-fetch requester
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_ack_o;
    logic [DW-1:0] if_data_o;
    // load/store requester
    logic          mem_req_i;
    logic          mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [3:0]    mem_sel_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_ack_o;
    logic [DW-1:0] mem_data_o;
    // RAM port
    logic          ram_ce_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_sel_o;
    logic [DW-1:0] ram_data_o;
    logic [DW-1:0] ram_data_i;
    // pipeline control
    logic          stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  ram_data_i,
        output if_ack_o, if_data_o, mem_ack_o, mem_data_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output ram_data_i,
        input  if_ack_o, if_data_o, mem_ack_o, mem_data_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous RAM port between instruction fetch (IF) and
//   load/store (MEM). One transaction at a time: IDLE picks a winner and
//   latches its payload onto the RAM port, BUSY holds it for RAM_LAT cycles,
//   DONE presents a one-cycle ack together with the captured read data.
//   Request at IDLE cycle T -> ack at T+RAM_LAT+1; one transaction every
//   RAM_LAT+2 cycles.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - mem_port_arbiter_if.slave (requesters, RAM port, stall_o)
//   Parameters: RAM_LAT (1..15), AW, DW.
//   Build option: define ARB_RR_EN for round-robin arbitration between the
//   requesters; otherwise MEM always beats IF.
module mem_port_arbiter #(
    parameter int RAM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_last_mem;   // last grant went to MEM (reset: IF)
    logic          r_win_mem;    // current transaction belongs to MEM
    logic          r_if_ack;
    logic          r_mem_ack;
    logic [DW-1:0] r_if_data;
    logic [DW-1:0] r_mem_data;
    logic          r_ce;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_sel;
    logic [DW-1:0] r_wdata;

    logic          w_any_req;
    logic          w_pick_mem;

    assign w_any_req = bus.if_req_i | bus.mem_req_i;

`ifdef ARB_RR_EN
    // Contended: hand the port to whoever did not have it last time.
    always_comb begin
        w_pick_mem = bus.mem_req_i;
        if (bus.mem_req_i && bus.if_req_i)
            w_pick_mem = ~r_last_mem;
    end
`else
    // Fixed priority: MEM wins whenever it asks; IF can starve.
    always_comb begin
        w_pick_mem = bus.mem_req_i;
    end
    logic w_unused_last;
    assign w_unused_last = r_last_mem;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last_mem <= 1'b0;
            r_win_mem  <= 1'b0;
            r_if_ack   <= 1'b0;
            r_mem_ack  <= 1'b0;
            r_if_data  <= '0;
            r_mem_data <= '0;
            r_ce       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_sel      <= 4'd0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win_mem  <= w_pick_mem;
                        r_last_mem <= w_pick_mem;
                        r_ce       <= 1'b1;
                        r_cnt      <= LAT_M1;
                        r_state    <= S_BUSY;
                        if (w_pick_mem) begin
                            r_we    <= bus.mem_we_i;
                            r_addr  <= bus.mem_addr_i;
                            r_sel   <= bus.mem_sel_i;
                            r_wdata <= bus.mem_data_i;
                        end else begin
                            // fetch is always a full-word read
                            r_we    <= 1'b0;
                            r_addr  <= bus.if_addr_i;
                            r_sel   <= 4'hF;
                            r_wdata <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_win_mem) begin
                            r_mem_ack <= 1'b1;
                            // a store keeps the previous load data visible
                            if (!r_we)
                                r_mem_data <= bus.ram_data_i;
                        end else begin
                            r_if_ack  <= 1'b1;
                            r_if_data <= bus.ram_data_i;
                        end
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_if_ack  <= 1'b0;
                    r_mem_ack <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_ack_o   = r_if_ack;
    assign bus.if_data_o  = r_if_data;
    assign bus.mem_ack_o  = r_mem_ack;
    assign bus.mem_data_o = r_mem_data;
    assign bus.ram_ce_o   = r_ce;
    assign bus.ram_we_o   = r_we;
    assign bus.ram_addr_o = r_addr;
    assign bus.ram_sel_o  = r_sel;
    assign bus.ram_data_o = r_wdata;

    // Stall while any requester is waiting; its own ack cycle releases it.
    assign bus.stall_o = (bus.if_req_i & ~r_if_ack) | (bus.mem_req_i & ~r_mem_ack);
endmodule
